// File: rtl/riscv_instr_port_arbiter.sv
// Two-master arbiter for one req/gnt/rvalid instruction-memory port.
// Round-robin selection held until grant; an ID FIFO routes in-order responses back.
module riscv_instr_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a request transfers in any cycle where req and gnt are both high;
  // the address must stay stable while req is high and ungranted; each accepted
  // request is answered by exactly one rvalid, in order, at least one cycle later.

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } state_e;

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  state_e                     state_q, state_d;
  logic                       last_q, last_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;

  logic full, winner, sel, sel_req, push, pop, cnt_nz, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Selection and memory-side request
  always_comb begin
    full   = (cnt_q == CNT_MAX);
    cnt_nz = (cnt_q != '0);
    winner = 1'b0;
    if (m0_req_i && m1_req_i) winner = ~last_q;
    else if (m1_req_i)        winner = 1'b1;
    case (state_q)
      HOLD0:   sel = 1'b0;
      HOLD1:   sel = 1'b1;
      default: sel = winner;
    endcase
    sel_req    = sel ? m1_req_i : m0_req_i;
    mem_req_o  = sel_req & ~full;
    mem_addr_o = sel_req ? (sel ? m1_addr_i : m0_addr_i) : '0;
    push       = mem_req_o & mem_gnt_i;
    pop        = mem_rvalid_i & cnt_nz;
    m0_gnt_o   = push & ~sel;
    m1_gnt_o   = push & sel;
    head        = ids_q[rd_ptr_q];
    m0_rvalid_o = pop & ~head;
    m1_rvalid_o = pop & head;
    m0_rdata_o  = mem_rdata_i;
    m1_rdata_o  = mem_rdata_i;
    err_o       = mem_rvalid_i & ~cnt_nz;
    busy_o      = cnt_nz | mem_req_o;
    dbg_state_o = state_q;
  end

  // FSM next state and round-robin pointer
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB: begin
        if (sel_req) begin
          if (push) last_d = sel;
          else      state_d = sel ? HOLD1 : HOLD0;
        end
      end
      HOLD0, HOLD1: begin
        if (!sel_req) begin
          state_d = ARB;
        end else if (push) begin
          last_d  = sel;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Outstanding-ID FIFO; a simultaneous push and pop keeps the count
  always_comb begin
    ids_d    = ids_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      ids_d[wr_ptr_q] = sel;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ids_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ids_q    <= ids_d;
    end
  end

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// Directed bench for riscv_instr_port_arbiter: expected grants and responses are
// queued by the stimulus and checked by an independent monitor.
module tb_riscv_instr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, mem_addr_o;
  logic        mem_req_o, busy_o, err_o;
  logic [1:0]  dbg_state_o;

  int tests = 0;
  int fails = 0;

  logic [1:0]  gnt_q[$];
  logic [34:0] rsp_q[$];

  riscv_instr_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // kind 0: routed to m0, 1: routed to m1, 2: dropped with err_o
  function automatic logic [34:0] exp_rsp(input int kind, input logic [31:0] d);
    case (kind)
      0:       return {3'b001, d};
      1:       return {3'b010, d};
      default: return {3'b100, d};
    endcase
  endfunction

  // Driver: inputs change 1 time unit after the rising edge; returns at the falling edge
  task automatic drive(input logic r0, input logic [31:0] a0, input logic r1,
                       input logic [31:0] a1, input logic g, input logic rv,
                       input logic [31:0] rd);
    @(posedge clk); #1;
    m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
    mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    m0_req = 0; m0_addr = '0; m1_req = 0; m1_addr = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_gnt_o || m1_gnt_o) begin
        if (gnt_q.size() == 0) check("unexpected_gnt", {62'd0, m1_gnt_o, m0_gnt_o}, 64'd0);
        else check("gnt_order", {62'd0, m1_gnt_o, m0_gnt_o}, {62'd0, gnt_q.pop_front()});
      end
      if (m0_rvalid_o || m1_rvalid_o || err_o) begin
        if (rsp_q.size() == 0)
          check("unexpected_rsp", {61'd0, err_o, m1_rvalid_o, m0_rvalid_o}, 64'd0);
        else
          check("rsp_route", {29'd0, err_o, m1_rvalid_o, m0_rvalid_o,
                              (m1_rvalid_o ? m1_rdata_o : m0_rdata_o)},
                {29'd0, rsp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset state
    pulse_reset();
    check("reset_outputs", {56'd0, mem_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o,
                            m1_rvalid_o, busy_o, err_o, 1'b0}, 64'd0);
    check("reset_addr", {32'd0, mem_addr_o}, 64'd0);
    check("reset_state", {62'd0, dbg_state_o}, 64'd0);

    // Single fetch
    gnt_q.push_back(2'b01);
    drive(1, 32'h1000, 0, 0, 1, 0, 0);
    check("single_req", {63'd0, mem_req_o}, 64'd1);
    check("single_addr", {32'd0, mem_addr_o}, 64'h1000);
    rsp_q.push_back(exp_rsp(0, 32'hDEAD_BEEF));
    drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("single_m1_quiet", {63'd0, m1_rvalid_o}, 64'd0);
    check("single_busy", {63'd0, busy_o}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("single_idle", {63'd0, busy_o}, 64'd0);

    // Contention right after reset: m0 first, then alternate
    pulse_reset();
    gnt_q.push_back(2'b01);
    drive(1, 32'h100, 1, 32'h200, 1, 0, 0);
    check("rr_addr0", {32'd0, mem_addr_o}, 64'h100);
    gnt_q.push_back(2'b10); rsp_q.push_back(exp_rsp(0, 32'hA0));
    drive(1, 32'h100, 1, 32'h200, 1, 1, 32'hA0);
    check("rr_addr1", {32'd0, mem_addr_o}, 64'h200);
    gnt_q.push_back(2'b01); rsp_q.push_back(exp_rsp(1, 32'hA1));
    drive(1, 32'h100, 1, 32'h200, 1, 1, 32'hA1);
    check("rr_addr2", {32'd0, mem_addr_o}, 64'h100);
    gnt_q.push_back(2'b10); rsp_q.push_back(exp_rsp(0, 32'hA2));
    drive(1, 32'h100, 1, 32'h200, 1, 1, 32'hA2);
    check("rr_addr3", {32'd0, mem_addr_o}, 64'h200);
    rsp_q.push_back(exp_rsp(1, 32'hA3));
    drive(0, 0, 0, 0, 0, 1, 32'hA3);

    // Hold stability: m0 served last, so m1 wins and is held
    gnt_q.push_back(2'b01);
    drive(1, 32'h100, 0, 0, 1, 0, 0);
    rsp_q.push_back(exp_rsp(0, 32'hB0));
    drive(0, 0, 0, 0, 0, 1, 32'hB0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100, 1, 32'h200, 0, 0, 0);
      check("hold_addr", {32'd0, mem_addr_o}, 64'h200);
      check("hold_m0_gnt", {63'd0, m0_gnt_o}, 64'd0);
    end
    gnt_q.push_back(2'b10);
    drive(1, 32'h100, 1, 32'h200, 1, 0, 0);
    check("hold_grant_addr", {32'd0, mem_addr_o}, 64'h200);
    gnt_q.push_back(2'b01);
    drive(1, 32'h100, 1, 32'h200, 1, 0, 0);
    check("hold_next_addr", {32'd0, mem_addr_o}, 64'h100);
    rsp_q.push_back(exp_rsp(1, 32'hC1));
    drive(0, 0, 0, 0, 0, 1, 32'hC1);
    rsp_q.push_back(exp_rsp(0, 32'hC0));
    drive(0, 0, 0, 0, 0, 1, 32'hC0);

    // Back-pressure at two outstanding
    gnt_q.push_back(2'b01);
    drive(1, 32'h100, 0, 0, 1, 0, 0);
    gnt_q.push_back(2'b01);
    drive(1, 32'h100, 0, 0, 1, 0, 0);
    drive(1, 32'h100, 0, 0, 1, 0, 0);
    check("bp_req_low", {63'd0, mem_req_o}, 64'd0);
    rsp_q.push_back(exp_rsp(0, 32'hD0));
    drive(1, 32'h100, 0, 0, 0, 1, 32'hD0);
    check("bp_no_bypass", {63'd0, mem_req_o}, 64'd0);
    gnt_q.push_back(2'b01);
    drive(1, 32'h100, 0, 0, 1, 0, 0);
    check("bp_reassert", {63'd0, mem_req_o}, 64'd1);
    rsp_q.push_back(exp_rsp(0, 32'hD1));
    drive(0, 0, 0, 0, 0, 1, 32'hD1);
    rsp_q.push_back(exp_rsp(0, 32'hD2));
    drive(0, 0, 0, 0, 0, 1, 32'hD2);

    // Same-cycle push and pop, then a stray rvalid
    gnt_q.push_back(2'b10);
    drive(0, 0, 1, 32'h200, 1, 0, 0);
    gnt_q.push_back(2'b01); rsp_q.push_back(exp_rsp(1, 32'hE1));
    drive(1, 32'h100, 0, 0, 1, 1, 32'hE1);
    check("pushpop_busy", {63'd0, busy_o}, 64'd1);
    rsp_q.push_back(exp_rsp(0, 32'hE0));
    drive(0, 0, 0, 0, 0, 1, 32'hE0);
    rsp_q.push_back(exp_rsp(2, 32'hE2));
    drive(0, 0, 0, 0, 0, 1, 32'hE2);
    check("err_pulse", {63'd0, err_o}, 64'd1);
    check("err_busy", {63'd0, busy_o}, 64'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("err_one_cycle", {63'd0, err_o}, 64'd0);

    // Reset with two outstanding discards them
    gnt_q.push_back(2'b01);
    drive(1, 32'h100, 0, 0, 1, 0, 0);
    gnt_q.push_back(2'b10);
    drive(0, 0, 1, 32'h200, 1, 0, 0);
    check("pre_reset_busy", {63'd0, busy_o}, 64'd1);
    pulse_reset();
    rsp_q.push_back(exp_rsp(2, 32'hF0));
    drive(0, 0, 0, 0, 0, 1, 32'hF0);
    check("post_reset_err0", {63'd0, err_o}, 64'd1);
    rsp_q.push_back(exp_rsp(2, 32'hF1));
    drive(0, 0, 0, 0, 0, 1, 32'hF1);
    check("post_reset_err1", {63'd0, err_o}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("post_reset_idle", {62'd0, busy_o, err_o}, 64'd0);

    // Final report
    check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
